// File: rtl/ret_rob_sched_if.sv
// Bus bundle for the per-parent return reorder scheduler.
// master drives allocs/returns/pops; slave is the scheduler.
interface ret_rob_sched_if #(
  parameter int PARENT     = 4,
  parameter int LOG_PARENT = (PARENT == 1) ? 1 : $clog2(PARENT),
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = $clog2(DEPTH),
  parameter int DW         = 34
);
  logic                  alloc_vld_i;
  logic [LOG_PARENT-1:0] alloc_parent_i;
  logic                  alloc_rdy_o;
  logic [SEQ_W-1:0]      alloc_seq_o;
  logic                  ret_vld_i;
  logic [LOG_PARENT-1:0] ret_parent_i;
  logic [SEQ_W-1:0]      ret_seq_i;
  logic [DW-1:0]         ret_data_i;
  logic [PARENT-1:0]     parent_empty_n_o;
  logic [DW-1:0]         parent_dout_o [PARENT];
  logic [PARENT-1:0]     parent_pop_i;
  logic                  ret_err_o;

  modport master (
    output alloc_vld_i, alloc_parent_i,
    input  alloc_rdy_o, alloc_seq_o,
    output ret_vld_i, ret_parent_i,
    output ret_seq_i, ret_data_i,
    input  parent_empty_n_o, parent_dout_o,
    output parent_pop_i,
    input  ret_err_o
  );

  modport slave (
    input  alloc_vld_i, alloc_parent_i,
    output alloc_rdy_o, alloc_seq_o,
    input  ret_vld_i, ret_parent_i,
    input  ret_seq_i, ret_data_i,
    output parent_empty_n_o, parent_dout_o,
    input  parent_pop_i,
    output ret_err_o
  );
endinterface

// File: rtl/ret_rob_sched.sv
// Per-parent return reorder scheduler: releases child
// returns to each parent strictly in call-issue order.
module ret_rob_sched #(
  parameter int PARENT     = 4,
  parameter int LOG_PARENT = (PARENT == 1) ? 1 : $clog2(PARENT),
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = $clog2(DEPTH),
  parameter int DW         = 34
) (
  input  logic          clk,
  input  logic          rstn,
  ret_rob_sched_if.slave bus
);
  localparam logic [SEQ_W:0] FULL = (SEQ_W+1)'(DEPTH);

  logic [SEQ_W:0]    cnt_q [PARENT];
  logic [SEQ_W:0]    cnt_d [PARENT];
  logic [SEQ_W-1:0]  wp_q  [PARENT];
  logic [SEQ_W-1:0]  wp_d  [PARENT];
  logic [SEQ_W-1:0]  hp_q  [PARENT];
  logic [SEQ_W-1:0]  hp_d  [PARENT];
  logic [DEPTH-1:0]  al_q  [PARENT];
  logic [DEPTH-1:0]  al_d  [PARENT];
  logic [DEPTH-1:0]  fl_q  [PARENT];
  logic [DEPTH-1:0]  fl_d  [PARENT];
  logic [DW-1:0]     mem   [PARENT][DEPTH];
  logic [DW-1:0]     od_q  [PARENT];
  logic [DW-1:0]     od_d  [PARENT];
  logic [PARENT-1:0] ov_q;
  logic [PARENT-1:0] ov_d;
  logic [PARENT-1:0] free;
  logic [PARENT-1:0] rel;
  logic [PARENT-1:0] afire;
  logic [PARENT-1:0] rfire;
  logic              alloc_fire;
  logic              ret_ok;
  logic              err_q;
  logic              err_d;

  assign bus.alloc_rdy_o =
    cnt_q[bus.alloc_parent_i] < FULL;
  assign bus.alloc_seq_o = wp_q[bus.alloc_parent_i];
  assign alloc_fire =
    bus.alloc_vld_i & bus.alloc_rdy_o;

  // Only an allocated, still-empty slot may take a return.
  assign ret_ok = bus.ret_vld_i
    & al_q[bus.ret_parent_i][bus.ret_seq_i]
    & ~fl_q[bus.ret_parent_i][bus.ret_seq_i];
  assign err_d = bus.ret_vld_i & ~ret_ok;

  always_comb begin
    for (int p = 0; p < PARENT; p++) begin
      al_d[p]  = al_q[p];
      fl_d[p]  = fl_q[p];
      wp_d[p]  = wp_q[p];
      hp_d[p]  = hp_q[p];
      cnt_d[p] = cnt_q[p];
      ov_d[p]  = ov_q[p];
      od_d[p]  = od_q[p];
      afire[p] = alloc_fire &
        (bus.alloc_parent_i == LOG_PARENT'(p));
      rfire[p] = ret_ok &
        (bus.ret_parent_i == LOG_PARENT'(p));
      free[p] = ~ov_q[p] | bus.parent_pop_i[p];
      rel[p]  = free[p] & fl_q[p][hp_q[p]];
      if (afire[p]) begin
        al_d[p][wp_q[p]] = 1'b1;
        wp_d[p] = wp_q[p] + 1'b1;
      end
      if (rfire[p])
        fl_d[p][bus.ret_seq_i] = 1'b1;
      if (rel[p]) begin
        al_d[p][hp_q[p]] = 1'b0;
        fl_d[p][hp_q[p]] = 1'b0;
        hp_d[p] = hp_q[p] + 1'b1;
        ov_d[p] = 1'b1;
        od_d[p] = mem[p][hp_q[p]];
      end else if (free[p]) begin
        ov_d[p] = 1'b0;
      end
      case ({afire[p], rel[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + 1'b1;
        2'b01:   cnt_d[p] = cnt_q[p] - 1'b1;
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < PARENT; p++) begin
        cnt_q[p] <= '0;
        wp_q[p]  <= '0;
        hp_q[p]  <= '0;
        al_q[p]  <= '0;
        fl_q[p]  <= '0;
        od_q[p]  <= '0;
      end
      ov_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int p = 0; p < PARENT; p++) begin
        cnt_q[p] <= cnt_d[p];
        wp_q[p]  <= wp_d[p];
        hp_q[p]  <= hp_d[p];
        al_q[p]  <= al_d[p];
        fl_q[p]  <= fl_d[p];
        od_q[p]  <= od_d[p];
      end
      ov_q  <= ov_d;
      err_q <= err_d;
    end
  end

  // Payload store needs no reset: filled bits gate every read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PARENT; p++)
      if (rfire[p])
        mem[p][bus.ret_seq_i] <= bus.ret_data_i;
  end

  assign bus.parent_empty_n_o = ov_q;
  assign bus.ret_err_o        = err_q;

  for (genvar g = 0; g < PARENT; g++) begin : g_out
    assign bus.parent_dout_o[g] = od_q[g];
  end
endmodule
